doodle_game_ctrl: RTL and testbench



---
 rtl/doodle_pkg.sv | 25 ++
 rtl/doodle_game_ctrl_key_edge_det.sv | 34 +++
 rtl/doodle_game_ctrl.sv | 161 ++++++++++++++++
 tb/tb_doodle_game_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/doodle_pkg.sv
// rtl/doodle_pkg.sv - shared types and key constants for the doodle game controller
package doodle_pkg;

  // Top-level game flow
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    FALL = 2'b10,
    OVER = 2'b11
  } game_state_t;

  // Doodler pose as seen by the sprite logic
  typedef enum logic [1:0] {
    D_LEFT  = 2'b00,
    D_RIGHT = 2'b01,
    D_SHOOT = 2'b10
  } doodler_state_t;

  localparam logic [7:0] KEY_NONE      = 8'h00;
  localparam logic [7:0] KEY_START_DEF = 8'h2C;
  localparam logic [7:0] KEY_SHOOT_DEF = 8'h1A;
  localparam logic [7:0] KEY_LEFT_DEF  = 8'h04;
  localparam logic [7:0] KEY_RIGHT_DEF = 8'h07;

endpackage

// File: rtl/doodle_game_ctrl_key_edge_det.sv
// rtl/doodle_game_ctrl_key_edge_det.sv - press edge detector for one key over both keycode inputs
module key_edge_det
  import doodle_pkg::*;
#(
  parameter logic [7:0] KEY = KEY_START_DEF
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic [7:0] keycode_ext,
  output logic       key_edge
);

  logic pressed;
  logic last_q;
  logic armed_q;

  // Either keycode slot may carry the key
  assign pressed  = (keycode == KEY) || (keycode_ext == KEY);
  // A key held across reset must be released once before it can fire
  assign key_edge = pressed && !last_q && armed_q;

  // Key history and post-reset arm flag
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      last_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      last_q <= pressed;
      if (keycode == KEY_NONE) armed_q <= 1'b1;
    end
  end

endmodule

// File: rtl/doodle_game_ctrl.sv
// rtl/doodle_game_ctrl.sv - frame-rate game sequencer, pose control, hit gating and score
module doodle_game_ctrl
  import doodle_pkg::*;
#(
  parameter int         SHOOT_FRAMES = 8,
  parameter int         FALL_FRAMES  = 90,
  parameter logic [7:0] KEY_START    = KEY_START_DEF,
  parameter logic [7:0] KEY_SHOOT    = KEY_SHOOT_DEF,
  parameter logic [7:0] KEY_LEFT     = KEY_LEFT_DEF,
  parameter logic [7:0] KEY_RIGHT    = KEY_RIGHT_DEF
) (
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [7:0]  keycode,
  input  logic [7:0]  keycode_ext,
  input  logic        plat_hit,
  input  logic        spring_hit,
  input  logic [9:0]  ball_y_motion,
  input  logic        drop,
  input  logic [9:0]  distance,
  output logic        doodler_rst,
  output logic [1:0]  doodler_state,
  output logic        collision,
  output logic        gain,
  output logic [31:0] distance_sum,
  output logic [1:0]  game_state,
  output logic        game_over
);

  localparam int SW = $clog2(SHOOT_FRAMES + 1);
  localparam int FW = $clog2(FALL_FRAMES);
  localparam logic [SW-1:0] SHOOT_LOAD = SW'(SHOOT_FRAMES);
  localparam logic [FW-1:0] FALL_LOAD  = FW'(FALL_FRAMES - 1);

  game_state_t   state;
  logic [SW-1:0] shoot_cnt;
  logic [SW-1:0] shoot_next;
  logic [FW-1:0] fall_cnt;
  logic          facing_q;
  logic          facing_next;
  logic          start_edge;
  logic          shoot_edge;
  logic          left_p;
  logic          right_p;
  logic          falling;
  logic [32:0]   sum_wide;
  logic [31:0]   sum_sat;

  key_edge_det #(.KEY(KEY_START)) u_start (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .keycode    (keycode),
    .keycode_ext(keycode_ext),
    .key_edge   (start_edge)
  );

  key_edge_det #(.KEY(KEY_SHOOT)) u_shoot (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .keycode    (keycode),
    .keycode_ext(keycode_ext),
    .key_edge   (shoot_edge)
  );

  assign game_state = state;
  assign left_p     = (keycode == KEY_LEFT)  || (keycode_ext == KEY_LEFT);
  assign right_p    = (keycode == KEY_RIGHT) || (keycode_ext == KEY_RIGHT);
  // Only downward motion may bounce; zero velocity is not falling
  assign falling    = !ball_y_motion[9] && (ball_y_motion != 10'd0);
  // Score adds with saturation instead of wrapping
  assign sum_wide   = {1'b0, distance_sum} + {23'd0, distance};
  assign sum_sat    = sum_wide[32] ? 32'hFFFF_FFFF : sum_wide[31:0];

  // Next shoot count and facing; a new press retriggers the full shoot time
  always_comb begin
    shoot_next = shoot_cnt;
    if (shoot_edge) begin
      shoot_next = SHOOT_LOAD;
    end else if (shoot_cnt != '0) begin
      shoot_next = shoot_cnt - 1'b1;
    end
    facing_next = facing_q;
    if (left_p) begin
      facing_next = 1'b0;
    end else if (right_p) begin
      facing_next = 1'b1;
    end
  end

  // Game FSM with registered outputs, pose and score
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state         <= IDLE;
      doodler_rst   <= 1'b1;
      doodler_state <= D_RIGHT;
      collision     <= 1'b0;
      gain          <= 1'b0;
      distance_sum  <= 32'd0;
      game_over     <= 1'b0;
      shoot_cnt     <= '0;
      fall_cnt      <= '0;
      facing_q      <= 1'b1;
    end else begin
      collision <= 1'b0;
      gain      <= 1'b0;

      if (state == PLAY || state == FALL) begin
        shoot_cnt <= shoot_next;
        if (shoot_next != '0) begin
          doodler_state <= D_SHOOT;
        end else begin
          facing_q      <= facing_next;
          doodler_state <= facing_next ? D_RIGHT : D_LEFT;
        end
      end

      case (state)
        IDLE: begin
          doodler_rst <= 1'b1;
          if (start_edge) begin
            state        <= PLAY;
            distance_sum <= 32'd0;
            doodler_rst  <= 1'b0;
          end
        end
        PLAY: begin
          doodler_rst  <= 1'b0;
          distance_sum <= sum_sat;
          if (drop) begin
            state    <= FALL;
            fall_cnt <= FALL_LOAD;
          end else begin
            gain      <= spring_hit && falling;
            collision <= plat_hit && falling && !spring_hit;
          end
        end
        FALL: begin
          doodler_rst <= 1'b0;
          if (fall_cnt == '0) begin
            state       <= OVER;
            doodler_rst <= 1'b1;
            game_over   <= 1'b1;
          end else begin
            fall_cnt <= fall_cnt - 1'b1;
          end
        end
        default: begin
          doodler_rst <= 1'b1;
          game_over   <= 1'b1;
          if (start_edge) begin
            state        <= PLAY;
            distance_sum <= 32'd0;
            doodler_rst  <= 1'b0;
            game_over    <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_doodle_game_ctrl.sv
// tb/tb_doodle_game_ctrl.sv - scoreboard bench for doodle_game_ctrl
module tb_doodle_game_ctrl;

  logic        Reset;
  logic        frame_clk;
  logic [7:0]  keycode;
  logic [7:0]  keycode_ext;
  logic        plat_hit;
  logic        spring_hit;
  logic [9:0]  ball_y_motion;
  logic        drop;
  logic [9:0]  distance;
  logic        doodler_rst;
  logic [1:0]  doodler_state;
  logic        collision;
  logic        gain;
  logic [31:0] distance_sum;
  logic [1:0]  game_state;
  logic        game_over;

  localparam int S_STATE = 0, S_RST = 1, S_DSTATE = 2, S_COLL = 3, S_GAIN = 4, S_SUM = 5, S_OVER = 6;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        sbq[$];
  int          vectors;
  int          miscompares;
  logic [31:0] exp_sum;

  doodle_game_ctrl dut (
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .keycode      (keycode),
    .keycode_ext  (keycode_ext),
    .plat_hit     (plat_hit),
    .spring_hit   (spring_hit),
    .ball_y_motion(ball_y_motion),
    .drop         (drop),
    .distance     (distance),
    .doodler_rst  (doodler_rst),
    .doodler_state(doodler_state),
    .collision    (collision),
    .gain         (gain),
    .distance_sum (distance_sum),
    .game_state   (game_state),
    .game_over    (game_over)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  function automatic logic [31:0] obs(int sel);
    case (sel)
      S_STATE:  return {30'd0, game_state};
      S_RST:    return {31'd0, doodler_rst};
      S_DSTATE: return {30'd0, doodler_state};
      S_COLL:   return {31'd0, collision};
      S_GAIN:   return {31'd0, gain};
      S_SUM:    return distance_sum;
      default:  return {31'd0, game_over};
    endcase
  endfunction

  function automatic logic [31:0] sat_add(logic [31:0] a, logic [9:0] b);
    logic [32:0] w;
    w = {1'b0, a} + {23'd0, b};
    return w[32] ? 32'hFFFF_FFFF : w[31:0];
  endfunction

  task automatic expect_out(string tag, int sel, logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.sel = sel;
    x.exp = e;
    sbq.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    logic [31:0] o;
    while (sbq.size() > 0) begin
      x = sbq.pop_front();
      o = obs(x.sel);
      vectors++;
      assert (o === x.exp) else begin
        miscompares++;
        $error("FAIL %s observed=%0h expected=%0h", x.tag, o, x.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
    drain();
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    exp_sum       = 32'd0;
    Reset         = 1'b1;
    keycode       = 8'h2C;
    keycode_ext   = 8'h00;
    plat_hit      = 1'b0;
    spring_hit    = 1'b0;
    ball_y_motion = 10'd0;
    drop          = 1'b0;
    distance      = 10'd0;

    // Reset values
    #12;
    expect_out("rst_state", S_STATE, 32'd0);
    expect_out("rst_drst", S_RST, 32'd1);
    expect_out("rst_dstate", S_DSTATE, 32'd1);
    expect_out("rst_coll", S_COLL, 32'd0);
    expect_out("rst_gain", S_GAIN, 32'd0);
    expect_out("rst_sum", S_SUM, 32'd0);
    expect_out("rst_over", S_OVER, 32'd0);
    drain();
    Reset = 1'b0;

    // Space held across reset release must not start the game
    expect_out("held_idle0", S_STATE, 32'd0);
    tick();
    expect_out("held_idle1", S_STATE, 32'd0);
    tick();
    keycode = 8'h00;
    expect_out("arm_idle", S_STATE, 32'd0);
    tick();
    keycode = 8'h2C;
    expect_out("start_state", S_STATE, 32'd1);
    expect_out("start_drst", S_RST, 32'd0);
    expect_out("start_sum", S_SUM, 32'd0);
    tick();
    keycode = 8'h00;

    // Platform bounce gating by vertical direction
    plat_hit = 1'b1;
    ball_y_motion = 10'd5;
    expect_out("coll_down", S_COLL, 32'd1);
    expect_out("coll_down_gain", S_GAIN, 32'd0);
    tick();
    ball_y_motion = 10'h3F8;
    expect_out("coll_up", S_COLL, 32'd0);
    tick();
    ball_y_motion = 10'd0;
    expect_out("coll_zero", S_COLL, 32'd0);
    tick();
    spring_hit = 1'b1;
    ball_y_motion = 10'd3;
    expect_out("spring_gain", S_GAIN, 32'd1);
    expect_out("spring_coll", S_COLL, 32'd0);
    tick();
    spring_hit = 1'b0;
    plat_hit = 1'b0;
    expect_out("hit_clear", S_GAIN, 32'd0);
    tick();

    // Score accumulation and saturation
    distance = 10'd9;
    for (int i = 0; i < 10; i++) begin
      exp_sum = sat_add(exp_sum, distance);
      expect_out("sum_acc", S_SUM, exp_sum);
      tick();
    end
    expect_out("sum_90", S_SUM, 32'd90);
    drain();
    @(negedge frame_clk);
    force dut.distance_sum = 32'hFFFF_FFFA;
    #1;
    release dut.distance_sum;
    exp_sum = sat_add(32'hFFFF_FFFA, distance);
    expect_out("sum_sat", S_SUM, 32'hFFFF_FFFF);
    tick();
    exp_sum = sat_add(exp_sum, distance);
    expect_out("sum_nowrap", S_SUM, exp_sum);
    tick();
    distance = 10'd0;

    // Shoot pose for exactly SHOOT_FRAMES, then back to facing
    keycode = 8'h1A;
    expect_out("shoot0", S_DSTATE, 32'd2);
    tick();
    keycode = 8'h00;
    for (int i = 1; i < 8; i++) begin
      expect_out("shoot_hold", S_DSTATE, 32'd2);
      tick();
    end
    expect_out("shoot_end_right", S_DSTATE, 32'd1);
    tick();
    keycode = 8'h1A;
    expect_out("shoot1", S_DSTATE, 32'd2);
    tick();
    keycode = 8'h00;
    keycode_ext = 8'h04;
    for (int i = 1; i < 8; i++) begin
      expect_out("shoot_hold_a", S_DSTATE, 32'd2);
      tick();
    end
    expect_out("shoot_end_left", S_DSTATE, 32'd0);
    tick();
    // Retrigger mid-shoot restarts the full shoot time
    keycode = 8'h1A;
    expect_out("retrig0", S_DSTATE, 32'd2);
    tick();
    keycode = 8'h00;
    for (int i = 0; i < 3; i++) begin
      expect_out("retrig_a", S_DSTATE, 32'd2);
      tick();
    end
    keycode = 8'h1A;
    expect_out("retrig_load", S_DSTATE, 32'd2);
    tick();
    keycode = 8'h00;
    for (int i = 1; i < 8; i++) begin
      expect_out("retrig_b", S_DSTATE, 32'd2);
      tick();
    end
    expect_out("retrig_end", S_DSTATE, 32'd0);
    tick();
    keycode_ext = 8'h00;
    keycode = 8'h07;
    expect_out("face_right", S_DSTATE, 32'd1);
    tick();
    keycode = 8'h04;
    keycode_ext = 8'h07;
    expect_out("both_left", S_DSTATE, 32'd0);
    tick();
    keycode = 8'h00;
    keycode_ext = 8'h00;
    expect_out("face_hold", S_DSTATE, 32'd0);
    tick();

    // Drop beats spring/platform in the same frame
    spring_hit = 1'b1;
    plat_hit = 1'b1;
    ball_y_motion = 10'd3;
    drop = 1'b1;
    expect_out("drop_state", S_STATE, 32'd2);
    expect_out("drop_gain", S_GAIN, 32'd0);
    expect_out("drop_coll", S_COLL, 32'd0);
    expect_out("drop_drst", S_RST, 32'd0);
    tick();
    spring_hit = 1'b0;
    plat_hit = 1'b0;
    drop = 1'b0;
    distance = 10'd5;
    for (int i = 1; i < 90; i++) begin
      expect_out("fall_hold", S_STATE, 32'd2);
      tick();
    end
    expect_out("over_state", S_STATE, 32'd3);
    expect_out("over_flag", S_OVER, 32'd1);
    expect_out("over_drst", S_RST, 32'd1);
    expect_out("over_sum", S_SUM, exp_sum);
    tick();
    expect_out("over_stay", S_STATE, 32'd3);
    tick();

    // Restart from OVER
    keycode = 8'h2C;
    expect_out("restart_state", S_STATE, 32'd1);
    expect_out("restart_sum", S_SUM, 32'd0);
    expect_out("restart_drst", S_RST, 32'd0);
    expect_out("restart_over", S_OVER, 32'd0);
    tick();
    exp_sum = 32'd0;
    keycode = 8'h00;
    distance = 10'd3;
    exp_sum = sat_add(exp_sum, distance);
    expect_out("restart_acc", S_SUM, exp_sum);
    tick();

    // Asynchronous reset in the middle of play
    #2;
    Reset = 1'b1;
    #1;
    expect_out("async_state", S_STATE, 32'd0);
    expect_out("async_drst", S_RST, 32'd1);
    expect_out("async_sum", S_SUM, 32'd0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
